// File: rtl/fifo_read_ctrl_if.sv
// Read-side FIFO bus: write-pointer input, memory read port and the
// registered output word handshake, grouped for the read controller.
interface fifo_read_ctrl_if #(
  parameter int DATASIZE = 16,
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE:0]   wptr_gray;
  logic [DATASIZE-1:0] rdata_mem;
  logic                dout_ready;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr_gray;
  logic                rempty;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic [ADDRSIZE:0]   rlevel;

  // Controller side
  modport master (
    input  wptr_gray, rdata_mem, dout_ready,
    output raddr, rptr_gray, rempty, dout, dout_valid, rlevel
  );

  // Environment side: write domain, memory and consumer
  modport slave (
    output wptr_gray, rdata_mem, dout_ready,
    input  raddr, rptr_gray, rempty, dout, dout_valid, rlevel
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO. Synchronises the write
// Gray pointer into rclk, keeps the binary/Gray read pointer, flags empty,
// reports occupancy and moves memory words into a registered output stage.
module fifo_read_ctrl #(
  parameter int DATASIZE    = 16,
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic              rclk,
  input logic              rrst,
  fifo_read_ctrl_if.master bus
);
  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0]       sync_reg [SYNC_STAGES];
  logic [PW-1:0]       wq_gray;
  logic [PW-1:0]       wq_bin;
  logic [PW-1:0]       rbin_reg;
  logic [PW-1:0]       rbin_next;
  logic [PW-1:0]       rgray_reg;
  logic [PW-1:0]       rgray_next;
  logic [PW-1:0]       rlevel_reg;
  logic                rempty_reg;
  logic                dout_valid_reg;
  logic [DATASIZE-1:0] dout_reg;
  logic                fetch;

  genvar gi;

  // Synchroniser chain: stage 0 samples the asynchronous Gray pointer
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First flop captures the write-domain pointer
        always_ff @(posedge rclk) begin
          if (rrst) sync_reg[0] <= '0;
          else      sync_reg[0] <= bus.wptr_gray;
        end
      end else begin : g_next
        // Later flops only shift, giving metastability time to settle
        always_ff @(posedge rclk) begin
          if (rrst) sync_reg[gi] <= '0;
          else      sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign wq_gray = sync_reg[SYNC_STAGES-1];

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits
  generate
    for (gi = 0; gi < PW; gi++) begin : g_g2b
      assign wq_bin[gi] = ^wq_gray[PW-1:gi];
    end
  endgenerate

  // A word leaves memory when one is there and the output stage can take it
  assign fetch      = !rempty_reg && (!dout_valid_reg || bus.dout_ready);
  assign rbin_next  = rbin_reg + PW'(fetch);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Read pointer, empty flag and occupancy, all from the post-fetch pointer
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_reg   <= '0;
      rgray_reg  <= '0;
      rempty_reg <= 1'b1;
      rlevel_reg <= '0;
    end else begin
      rbin_reg   <= rbin_next;
      rgray_reg  <= rgray_next;
      rempty_reg <= (rgray_next == wq_gray);
      rlevel_reg <= wq_bin - rbin_next;
    end
  end

  // Output stage: a fetch overwrites (consume-and-refill keeps valid high)
  always_ff @(posedge rclk) begin
    if (rrst) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else if (fetch) begin
      dout_reg       <= bus.rdata_mem;
      dout_valid_reg <= 1'b1;
    end else if (dout_valid_reg && bus.dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

  assign bus.raddr      = rbin_reg[ADDRSIZE-1:0];
  assign bus.rptr_gray  = rgray_reg;
  assign bus.rempty     = rempty_reg;
  assign bus.rlevel     = rlevel_reg;
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: table vectors, directed corner
// sequences and random traffic against a count-based reference model.
module tb_fifo_read_ctrl;
  localparam int SYNC = 2;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_read_ctrl_if #(.DATASIZE(16), .ADDRSIZE(4)) bus ();

  fifo_read_ctrl #(.DATASIZE(16), .ADDRSIZE(4), .SYNC_STAGES(SYNC)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  // Memory owned by the bench, read combinationally at raddr
  logic [15:0] mem [16];
  assign bus.rdata_mem = mem[bus.raddr];

  int n_err = 0;
  int n_chk = 0;

  // Write side state and log of every word written, in order
  int unsigned w = 0;
  logic [15:0] wlog [64];
  int unsigned cons = 0;

  // Reference model in unwrapped word counts
  int unsigned m_rd = 0;
  int unsigned m_sync [SYNC];
  bit          m_re = 1'b1;
  bit          m_dv = 1'b0;
  logic [15:0] m_dout = '0;
  int unsigned m_lvl = 0;

  typedef struct {
    bit          rst;
    bit          rdy;
    int          wtot;
    logic [15:0] wbase;
    logic [15:0] dout;
    bit          dv;
    bit          re;
    int          ra;
    int          gp;
    int          lvl;
  } vec_t;
  vec_t vt [16];

  function automatic logic [4:0] gray5(int unsigned b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic write_word(logic [15:0] d);
    mem[w[3:0]] = d;
    wlog[w % 64] = d;
    w++;
    bus.wptr_gray = gray5(w);
  endtask

  task automatic set_reset(bit r);
    rrst = r;
    if (r) begin
      w = 0;
      bus.wptr_gray = '0;
    end
  endtask

  // One clock: advance the model, let the edge pass, compare every output
  task automatic tick();
    bit          f;
    int unsigned rdn, wq;
    bit          nre, ndv;
    logic [15:0] nd;
    int unsigned nlvl;
    if (!rrst && bus.dout_valid && bus.dout_ready) begin
      chk("consumed_word", {16'h0, bus.dout}, {16'h0, wlog[cons % 64]});
      cons++;
    end
    f = 1'b0;
    if (rrst) begin
      rdn = 0; nre = 1'b1; ndv = 1'b0; nd = '0; nlvl = 0;
    end else begin
      wq   = m_sync[SYNC-1];
      f    = !m_re && (!m_dv || bus.dout_ready);
      rdn  = m_rd + (f ? 1 : 0);
      nre  = (rdn == wq);
      nlvl = wq - rdn;
      nd   = f ? wlog[m_rd % 64] : m_dout;
      ndv  = f ? 1'b1 : (m_dv && !bus.dout_ready);
    end
    @(posedge rclk);
    #1;
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = rrst ? 0 : m_sync[i-1];
    m_sync[0] = rrst ? 0 : w;
    if (rrst) cons = 0;
    m_rd = rdn; m_re = nre; m_dv = ndv; m_dout = nd; m_lvl = nlvl;
    chk("dout",       {16'h0, bus.dout},       {16'h0, m_dout});
    chk("dout_valid", {31'h0, bus.dout_valid}, {31'h0, m_dv});
    chk("rempty",     {31'h0, bus.rempty},     {31'h0, m_re});
    chk("raddr",      {28'h0, bus.raddr},      m_rd % 16);
    chk("rptr_gray",  {27'h0, bus.rptr_gray},  {27'h0, gray5(m_rd)});
    chk("rlevel",     {27'h0, bus.rlevel},     m_lvl);
    if (f && rdn == 16) chk("rptr_gray_16", {27'h0, bus.rptr_gray}, 32'h18);
    if (f && rdn == 32) chk("rptr_gray_32", {27'h0, bus.rptr_gray}, 32'h00);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < SYNC; i++) m_sync[i] = 0;
    bus.wptr_gray  = '0;
    bus.dout_ready = 1'b0;

    // Single word then backpressure, expectations worked out by hand
    vt[0]  = '{1'b1, 1'b1, 0, 16'h0,    16'h0,    1'b0, 1'b1, 0, 0, 0};
    vt[1]  = '{1'b0, 1'b1, 1, 16'hA5A5, 16'h0,    1'b0, 1'b1, 0, 0, 0};
    vt[2]  = '{1'b0, 1'b1, 1, 16'h0,    16'h0,    1'b0, 1'b1, 0, 0, 0};
    vt[3]  = '{1'b0, 1'b1, 1, 16'h0,    16'h0,    1'b0, 1'b0, 0, 0, 1};
    vt[4]  = '{1'b0, 1'b1, 1, 16'h0,    16'hA5A5, 1'b1, 1'b1, 1, 1, 0};
    vt[5]  = '{1'b0, 1'b1, 1, 16'h0,    16'hA5A5, 1'b0, 1'b1, 1, 1, 0};
    vt[6]  = '{1'b1, 1'b0, 0, 16'h0,    16'h0,    1'b0, 1'b1, 0, 0, 0};
    vt[7]  = '{1'b0, 1'b0, 4, 16'h1,    16'h0,    1'b0, 1'b1, 0, 0, 0};
    vt[8]  = '{1'b0, 1'b0, 4, 16'h0,    16'h0,    1'b0, 1'b1, 0, 0, 0};
    vt[9]  = '{1'b0, 1'b0, 4, 16'h0,    16'h0,    1'b0, 1'b0, 0, 0, 4};
    vt[10] = '{1'b0, 1'b0, 4, 16'h0,    16'h1,    1'b1, 1'b0, 1, 1, 3};
    vt[11] = '{1'b0, 1'b0, 4, 16'h0,    16'h1,    1'b1, 1'b0, 1, 1, 3};
    vt[12] = '{1'b0, 1'b1, 4, 16'h0,    16'h2,    1'b1, 1'b0, 2, 3, 2};
    vt[13] = '{1'b0, 1'b1, 4, 16'h0,    16'h3,    1'b1, 1'b0, 3, 2, 1};
    vt[14] = '{1'b0, 1'b1, 4, 16'h0,    16'h4,    1'b1, 1'b1, 4, 6, 0};
    vt[15] = '{1'b0, 1'b1, 4, 16'h0,    16'h4,    1'b0, 1'b1, 4, 6, 0};

    set_reset(1'b1);
    tick();
    set_reset(1'b0);

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      if (($urandom % 4) != 0 && (w - m_rd) < 16) write_word(16'($urandom));
      if (($urandom % 100) == 0) set_reset(1'b1);
      tick();
      set_reset(1'b0);
    end
    $display("random phase done, checks so far %0d", n_chk);

    // Table vectors (row 0 resets out of the random state)
    for (int r = 0; r < 16; r++) begin
      set_reset(vt[r].rst);
      bus.dout_ready = vt[r].rdy;
      if (!vt[r].rst)
        for (int k = 0; w < vt[r].wtot; k++) write_word(vt[r].wbase + 16'(k));
      tick();
      chk("vec_dout",   {16'h0, bus.dout},       {16'h0, vt[r].dout});
      chk("vec_valid",  {31'h0, bus.dout_valid}, {31'h0, vt[r].dv});
      chk("vec_empty",  {31'h0, bus.rempty},     {31'h0, vt[r].re});
      chk("vec_raddr",  {28'h0, bus.raddr},      vt[r].ra);
      chk("vec_gptr",   {27'h0, bus.rptr_gray},  vt[r].gp);
      chk("vec_level",  {27'h0, bus.rlevel},     vt[r].lvl);
      $display("vector %0d: dout=%h valid=%0d empty=%0d raddr=%0d level=%0d",
               r, bus.dout, bus.dout_valid, bus.rempty, bus.raddr, bus.rlevel);
    end
    set_reset(1'b0);

    // Full memory, then drain/refill across two pointer laps
    set_reset(1'b1); tick(); set_reset(1'b0);
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 16; k++) write_word(16'($urandom));
    for (int k = 0; k < 3; k++) tick();
    chk("full_level", {27'h0, bus.rlevel}, 32'd16);
    chk("full_empty", {31'h0, bus.rempty}, 32'd0);
    cyc = 0;
    while (m_rd < 40 && cyc < 2000) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      if (w < 40 && (w - m_rd) < 16 && $urandom_range(0, 1) == 1)
        write_word(16'($urandom));
      tick();
      cyc++;
    end
    chk("wrap_reads_done", m_rd, 32'd40);
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("wrap_consumed", cons, 32'd40);

    // Consume and refill in the same cycle
    set_reset(1'b1); tick(); set_reset(1'b0);
    bus.dout_ready = 1'b1;
    write_word(16'h0111); write_word(16'h0222); write_word(16'h0333);
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk("simul_d1", {16'h0, bus.dout}, 32'h0111);
    tick();
    chk("simul_v2", {31'h0, bus.dout_valid}, 32'd1);
    chk("simul_d2", {16'h0, bus.dout}, 32'h0222);
    tick();
    chk("simul_v3", {31'h0, bus.dout_valid}, 32'd1);
    chk("simul_d3", {16'h0, bus.dout}, 32'h0333);
    tick();
    chk("simul_drop", {31'h0, bus.dout_valid}, 32'd0);

    // Reset in the middle of a stream
    for (int k = 0; k < 12; k++) begin
      if ((w - m_rd) < 16) write_word(16'($urandom));
      tick();
    end
    chk("pre_reset_valid", {31'h0, bus.dout_valid}, 32'd1);
    set_reset(1'b1);
    tick();
    set_reset(1'b0);
    chk("mid_rst_valid", {31'h0, bus.dout_valid}, 32'd0);
    chk("mid_rst_empty", {31'h0, bus.rempty}, 32'd1);
    chk("mid_rst_dout",  {16'h0, bus.dout}, 32'd0);
    chk("mid_rst_gptr",  {27'h0, bus.rptr_gray}, 32'd0);
    tick();
    chk("post_rst_valid", {31'h0, bus.dout_valid}, 32'd0);
    chk("post_rst_empty", {31'h0, bus.rempty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
